// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed or unsigned.
// Results and {N,Z,C,V} flags are latched and held until the next operation completes.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             neg_q_reg, neg_r_reg, ovf_reg;

  logic [WIDTH:0]   shifted, trial;
  logic             q_bit;
  logic [WIDTH-1:0] dividend_mag, divisor_mag, q_fix, r_fix;
  logic             last_iter;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    case (state_reg)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Remainder shifted by one is WIDTH+1 bits; the trial difference's top bit is its sign.
  always_comb begin
    shifted      = {rem_reg, dvd_reg[WIDTH-1]};
    trial        = shifted - {1'b0, dsr_reg};
    q_bit        = ~trial[WIDTH];
    last_iter    = (count_reg == CNT_W'(WIDTH-1));
    dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    q_fix        = neg_q_reg ? -dvd_reg : dvd_reg;
    r_fix        = neg_r_reg ? -rem_reg : rem_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_reg     <= '0;
      dvd_reg     <= '0;
      dsr_reg     <= '0;
      count_reg   <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      flags       <= 4'b0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              flags       <= 4'b1001;
            end else begin
              rem_reg   <= '0;
              dvd_reg   <= dividend_mag;
              dsr_reg   <= divisor_mag;
              count_reg <= '0;
              neg_q_reg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r_reg <= is_signed && dividend[WIDTH-1];
              ovf_reg   <= is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                     && (divisor == '1);
            end
          end
        end
        CALC: begin
          rem_reg   <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd_reg   <= {dvd_reg[WIDTH-2:0], q_bit};
          count_reg <= count_reg + 1'b1;
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= 1'b0;
          flags       <= {q_fix[WIDTH-1], (q_fix == '0), 1'b0, ovf_reg};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .flags(flags)
  );

  always #5 clk = ~clk;

  // Truncating division reference using the language's own arithmetic.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dbz, output logic [3:0] f);
    int   sa, sb;
    logic v;
    sa  = a;
    sb  = b;
    v   = 1'b0;
    dbz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; v = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; v = 1'b1;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    f = {q[31], (q == 32'd0), 1'b0, v};
  endfunction

  // Issues one start and waits (bounded) for done; lat = edges from start to done, -1 on timeout.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_n);
    @(posedge clk);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    is_signed = ~s; dividend = $urandom; divisor = $urandom;
    lat = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, div_by_zero, flags} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {busy, done, div_by_zero, flags});
    end
    checks++;
    if ({quotient, remainder} !== 64'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {quotient, remainder});
    end
    @(negedge clk);
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_directed();
    logic        s_t [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_t [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b_t [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] eq, er;
    logic        ed;
    logic [3:0]  ef;
    int          lat, bn, el;
    for (int i = 0; i < 6; i++) begin
      do_op(s_t[i], a_t[i], b_t[i], lat, bn);
      model(s_t[i], a_t[i], b_t[i], eq, er, ed, ef);
      el = (b_t[i] == 0) ? 1 : 34;
      $display("directed s=%0d %h / %h -> q=%h r=%h dbz=%0d f=%b lat=%0d",
               s_t[i], a_t[i], b_t[i], quotient, remainder, div_by_zero, flags, lat);
      checks++;
      if (lat !== el) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, el); end
      checks++;
      if (quotient !== eq) begin errors++; $display("FAIL dir_quotient[%0d]: got %h expected %h", i, quotient, eq); end
      checks++;
      if (remainder !== er) begin errors++; $display("FAIL dir_remainder[%0d]: got %h expected %h", i, remainder, er); end
      checks++;
      if ({div_by_zero, flags} !== {ed, ef}) begin
        errors++; $display("FAIL dir_flags[%0d]: got %b expected %b", i, {div_by_zero, flags}, {ed, ef});
      end
      if (i == 0) begin
        checks++;
        if (bn !== 34) begin errors++; $display("FAIL dir_busy_cycles: got %0d expected 34", bn); end
      end
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL dir_done_pulse[%0d]: got %b expected 00", i, {done, busy}); end
    end
  endtask

  task automatic test_random();
    logic        s;
    logic [31:0] a, b, eq, er;
    logic        ed;
    logic [3:0]  ef;
    int          lat, bn, el, mode;
    for (int i = 0; i < 24; i++) begin
      s    = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = a;
        default: b = $urandom;
      endcase
      do_op(s, a, b, lat, bn);
      model(s, a, b, eq, er, ed, ef);
      el = (b == 0) ? 1 : 34;
      $display("random s=%0d %h / %h -> q=%h r=%h dbz=%0d f=%b lat=%0d",
               s, a, b, quotient, remainder, div_by_zero, flags, lat);
      checks++;
      if (lat !== el) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, el); end
      checks++;
      if ({quotient, remainder} !== {eq, er}) begin
        errors++; $display("FAIL rnd_result[%0d]: got q=%h r=%h expected q=%h r=%h", i, quotient, remainder, eq, er);
      end
      checks++;
      if ({div_by_zero, flags} !== {ed, ef}) begin
        errors++; $display("FAIL rnd_flags[%0d]: got %b expected %b", i, {div_by_zero, flags}, {ed, ef});
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] eq, er, gq, gr;
    logic        ed;
    logic [3:0]  ef, gf;
    int          k, ndone, dlat;
    model(1'b0, 32'd1000, 32'd3, eq, er, ed, ef);
    @(posedge clk);
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1; ndone = 0; dlat = -1; gq = '0; gr = '0; gf = '0;
    while (k < 60) begin
      if (k == 5 || k == 20) begin
        start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFF_FF00 + k; divisor = 32'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin dlat = k; gq = quotient; gr = remainder; gf = flags; end
      end
    end
    $display("busy_start 1000 / 3 -> q=%h r=%h f=%b lat=%0d dones=%0d", gq, gr, gf, dlat, ndone);
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", ndone); end
    checks++;
    if (dlat !== 34) begin errors++; $display("FAIL busy_latency: got %0d expected 34", dlat); end
    checks++;
    if ({gq, gr, gf} !== {eq, er, ef}) begin
      errors++; $display("FAIL busy_result: got q=%h r=%h f=%b expected q=%h r=%h f=%b", gq, gr, gf, eq, er, ef);
    end
  endtask

  task automatic test_start_in_done();
    logic [31:0] eq, er;
    logic        ed;
    logic [3:0]  ef;
    int          lat, bn;
    model(1'b0, 32'd50, 32'd6, eq, er, ed, ef);
    do_op(1'b0, 32'd50, 32'd6, lat, bn);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    $display("done_start 50 / 6 -> q=%h r=%h busy_after=%0d", quotient, remainder, busy);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored: got busy=%b expected 0", busy); end
    @(posedge clk); #1;
    checks++;
    if ({busy, quotient, remainder} !== {1'b0, eq, er}) begin
      errors++; $display("FAIL done_start_hold: got busy=%b q=%h r=%h expected busy=0 q=%h r=%h",
                         busy, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bn, ndone;
    @(posedge clk);
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd777; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    $display("reset_abort at cycle 10 -> busy=%0d q=%h r=%h", busy, quotient, remainder);
    checks++;
    if ({busy, done, div_by_zero, flags, quotient, remainder} !== 71'd0) begin
      errors++; $display("FAIL abort_clear: got busy=%b done=%b dbz=%b f=%b q=%h r=%h expected all 0",
                         busy, done, div_by_zero, flags, quotient, remainder);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    do_op(1'b0, 32'd5, 32'd5, lat, bn);
    $display("after_reset 5 / 5 -> q=%h r=%h f=%b lat=%0d", quotient, remainder, flags, lat);
    checks++;
    if ({quotient, remainder, div_by_zero, flags} !== {32'd1, 32'd0, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL post_reset_op: got q=%h r=%h dbz=%b f=%b expected q=1 r=0 dbz=0 f=0000",
                         quotient, remainder, div_by_zero, flags);
    end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL post_reset_latency: got %0d expected 34", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_start_in_done();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
